// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit positions,
// active-low digit selects and the pattern-to-ASCII map.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [3:0] DIG0     = 4'b1110;
    localparam logic [3:0] DIG1     = 4'b1101;
    localparam logic [3:0] DIG2     = 4'b1011;
    localparam logic [3:0] DIG3     = 4'b0111;
    localparam logic [3:0] DIG_IDLE = 4'b1111;

    localparam logic [7:0] BLANK_CODE   = 8'h20;
    localparam logic [7:0] UNKNOWN_CODE = 8'h3F;

    typedef struct packed {
        logic [6:0] pattern;
        logic [7:0] code;
    } asciiEntry_t;

    localparam int ASCII_ENTRIES = 17;

    // Hex digits plus dash; patterns are {a,b,c,d,e,f,g}.
    localparam asciiEntry_t ASCII_MAP [ASCII_ENTRIES] = '{
        {7'h7E, 8'h30}, {7'h30, 8'h31}, {7'h6D, 8'h32}, {7'h79, 8'h33},
        {7'h33, 8'h34}, {7'h5B, 8'h35}, {7'h5F, 8'h36}, {7'h70, 8'h37},
        {7'h7F, 8'h38}, {7'h7B, 8'h39}, {7'h77, 8'h41}, {7'h1F, 8'h62},
        {7'h4E, 8'h43}, {7'h3D, 8'h64}, {7'h4F, 8'h45}, {7'h47, 8'h46},
        {7'h01, 8'h2D}
    };

endpackage

// File: rtl/seg7_scan_decoder_to_ascii.sv
// Combinational 7-segment pattern to ASCII lookup (module seg7_to_ascii),
// used by the scan decoder when SEG7_ASCII_EN is defined.
module seg7_to_ascii
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [7:0] code_o
);

    always_comb begin
        code_o = UNKNOWN_CODE;
        if (pattern_i == 7'h00) begin
            code_o = BLANK_CODE;
        end
        for (int i = 0; i < ASCII_ENTRIES; i++) begin
            if (ASCII_MAP[i].pattern == pattern_i) begin
                code_o = ASCII_MAP[i].code;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Rebuilds the 4-character frame from a multiplexed 7-segment scan and emits new
// characters into a FIFO. Define SEG7_ASCII_EN to translate patterns to ASCII.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE     = 4,
    parameter int CONFIRM    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [27:0] frame,
    output logic        frame_valid,
    output logic [7:0]  char_code,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        overflow,
    output logic        dig_err
);

    localparam int             PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0]     CONFIRM_N   = 4'(CONFIRM);
    localparam logic [PTR_W:0] FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

    logic [6:0]  seg1_q, seg2_q;
    logic [3:0]  dig1_q, dig2_q, digPrev_q;
    logic [7:0]  settle_q, settle_d;
    logic        sampled_q, sampled_d;
    logic [6:0]  slot_q [4];
    logic [6:0]  slot_d [4];
    logic [3:0]  mask_q, mask_d;
    logic [27:0] cand_q, cand_d;
    logic [3:0]  count_q, count_d;
    logic [27:0] frame_q, frame_d;
    logic        fv_q, fv_d;
    logic [27:0] pushBuf_q, pushBuf_d;
    logic [2:0]  pushRem_q, pushRem_d;
    logic        derr_q, derr_d;

    logic [6:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [PTR_W:0]   fill_q;
    logic             ovf_q;

    logic        fire, digOne;
    logic [1:0]  digIdx;
    logic [27:0] assembled;
    logic        push, pop, pushOk, fifoFull;
    logic [7:0]  headCode;

    // Digit select resets to idle so the synchroniser never looks like a multi-low select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg1_q    <= '0;
            seg2_q    <= '0;
            dig1_q    <= DIG_IDLE;
            dig2_q    <= DIG_IDLE;
            digPrev_q <= DIG_IDLE;
        end else begin
            seg1_q    <= seg_in;
            seg2_q    <= seg1_q;
            dig1_q    <= dig_in;
            dig2_q    <= dig1_q;
            digPrev_q <= dig2_q;
        end
    end

    always_comb begin
        digOne = 1'b0;
        digIdx = 2'd0;
        case (dig2_q)
            DIG0:    begin digOne = 1'b1; digIdx = 2'd0; end
            DIG1:    begin digOne = 1'b1; digIdx = 2'd1; end
            DIG2:    begin digOne = 1'b1; digIdx = 2'd2; end
            DIG3:    begin digOne = 1'b1; digIdx = 2'd3; end
            default: ;
        endcase
        fire      = (dig2_q == digPrev_q) && !sampled_q && (settle_q == SETTLE_LAST);
        assembled = {slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
    end

    // Capture, frame confirmation and the accept/push sequencer; the push
    // sequencer drains pushBuf from the top, so resyncs emit d3 first.
    always_comb begin
        settle_d  = settle_q;
        sampled_d = sampled_q;
        slot_d    = slot_q;
        mask_d    = (mask_q == 4'hF) ? 4'h0 : mask_q;
        derr_d    = derr_q;
        cand_d    = cand_q;
        count_d   = count_q;
        frame_d   = frame_q;
        fv_d      = 1'b0;
        pushBuf_d = pushBuf_q;
        pushRem_d = pushRem_q;

        if (dig2_q != digPrev_q) begin
            settle_d  = 8'd0;
            sampled_d = 1'b0;
        end else if (!sampled_q) begin
            if (settle_q == SETTLE_LAST) begin
                sampled_d = 1'b1;
            end else begin
                settle_d = settle_q + 8'd1;
            end
        end

        if (fire) begin
            if (digOne) begin
                slot_d[digIdx] = seg2_q;
                mask_d[digIdx] = 1'b1;
            end else if (dig2_q != DIG_IDLE) begin
                derr_d = 1'b1;
            end
        end

        if (mask_q == 4'hF) begin
            if (assembled == cand_q) begin
                if (count_q != 4'hF) begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                cand_d  = assembled;
                count_d = 4'd1;
            end
        end

        if (pushRem_q != 3'd0) begin
            pushBuf_d = {pushBuf_q[20:0], 7'h00};
            pushRem_d = pushRem_q - 3'd1;
        end else if ((count_q == CONFIRM_N) && (cand_q != frame_q)) begin
            frame_d = cand_q;
            fv_d    = 1'b1;
            if (cand_q[27:7] == frame_q[20:0]) begin
                pushBuf_d = {cand_q[6:0], 21'h0};
                pushRem_d = 3'd1;
            end else begin
                pushBuf_d = cand_q;
                pushRem_d = 3'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q  <= '0;
            sampled_q <= 1'b0;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            mask_q    <= '0;
            derr_q    <= 1'b0;
            cand_q    <= '0;
            count_q   <= '0;
            frame_q   <= '0;
            fv_q      <= 1'b0;
            pushBuf_q <= '0;
            pushRem_q <= '0;
        end else begin
            settle_q  <= settle_d;
            sampled_q <= sampled_d;
            slot_q    <= slot_d;
            mask_q    <= mask_d;
            derr_q    <= derr_d;
            cand_q    <= cand_d;
            count_q   <= count_d;
            frame_q   <= frame_d;
            fv_q      <= fv_d;
            pushBuf_q <= pushBuf_d;
            pushRem_q <= pushRem_d;
        end
    end

    assign push     = (pushRem_q != 3'd0);
    assign pop      = char_valid && char_ready;
    assign fifoFull = (fill_q == FIFO_FULL);
    assign pushOk   = push && (!fifoFull || pop);

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pushOk) begin
                mem_q[wrPtr_q] <= pushBuf_q[27:21];
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (push && !pushOk) begin
                ovf_q <= 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (pushOk && !pop) begin
                fill_q <= fill_q + 1'b1;
            end else if (!pushOk && pop) begin
                fill_q <= fill_q - 1'b1;
            end
        end
    end

`ifdef SEG7_ASCII_EN
    seg7_to_ascii u_ascii (
        .pattern_i (mem_q[rdPtr_q]),
        .code_o    (headCode)
    );
`else
    assign headCode = {1'b0, mem_q[rdPtr_q]};
`endif

    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign char_valid  = (fill_q != '0);
    assign char_code   = char_valid ? headCode : 8'h00;
    assign overflow    = ovf_q;
    assign dig_err     = derr_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans plus randomized
// scroll/resync traffic compared against a frame-level reference model.
module tb_seg7_scan_decoder;

    localparam int SETTLE     = 4;
    localparam int CONFIRM    = 2;
    localparam int FIFO_DEPTH = 4;

    localparam logic [27:0] F0123 = {7'h7E, 7'h30, 7'h6D, 7'h79};
    localparam logic [27:0] F1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
    localparam logic [27:0] FALTA = {7'h5F, 7'h70, 7'h7F, 7'h7B};
    localparam logic [27:0] FALTB = {7'h77, 7'h1F, 7'h4E, 7'h3D};
    localparam logic [27:0] FERR  = {7'h5B, 7'h5F, 7'h70, 7'h01};
    localparam logic [27:0] FX    = {7'h7F, 7'h7B, 7'h77, 7'h1F};
    localparam logic [27:0] FY    = {7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_in;
    logic [27:0] frame;
    logic        frame_valid;
    logic [7:0]  char_code;
    logic        char_valid;
    logic        char_ready;
    logic        overflow;
    logic        dig_err;

    int errors = 0;
    int checks = 0;

    logic [27:0] obsFrames [$];
    logic [27:0] expFrames [$];
    logic [7:0]  obsChars  [$];
    logic [7:0]  expChars  [$];

    logic [27:0] modelCand, modelAcc, nextFrame;
    int          modelCnt, modelHeld, reps;
    logic        modelOvf, modelDigErr;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .SETTLE     (SETTLE),
        .CONFIRM    (CONFIRM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_in      (dig_in),
        .frame       (frame),
        .frame_valid (frame_valid),
        .char_code   (char_code),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .overflow    (overflow),
        .dig_err     (dig_err)
    );

    // Record every accepted frame and every character handed to the consumer.
    always @(negedge clk) begin
        if (frame_valid) obsFrames.push_back(frame);
        if (char_valid && char_ready) obsChars.push_back(char_code);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] expCode(input logic [6:0] p);
`ifdef SEG7_ASCII_EN
        case (p)
            7'h00: return 8'h20;
            7'h7E: return 8'h30;  7'h30: return 8'h31;  7'h6D: return 8'h32;
            7'h79: return 8'h33;  7'h33: return 8'h34;  7'h5B: return 8'h35;
            7'h5F: return 8'h36;  7'h70: return 8'h37;  7'h7F: return 8'h38;
            7'h7B: return 8'h39;  7'h77: return 8'h41;  7'h1F: return 8'h62;
            7'h4E: return 8'h43;  7'h3D: return 8'h64;  7'h4F: return 8'h45;
            7'h47: return 8'h46;  7'h01: return 8'h2D;
            default: return 8'h3F;
        endcase
`else
        return {1'b0, p};
`endif
    endfunction

    task automatic modelReset();
        modelCand   = '0;
        modelAcc    = '0;
        modelCnt    = 0;
        modelHeld   = 0;
        modelOvf    = 1'b0;
        modelDigErr = 1'b0;
        obsFrames.delete();
        obsChars.delete();
        expFrames.delete();
        expChars.delete();
    endtask

    // A stalled consumer lets the FIFO hold FIFO_DEPTH characters; later ones are lost.
    task automatic modelPush(input logic [6:0] p);
        if (char_ready) begin
            expChars.push_back(expCode(p));
        end else if (modelHeld < FIFO_DEPTH) begin
            expChars.push_back(expCode(p));
            modelHeld++;
        end else begin
            modelOvf = 1'b1;
        end
    endtask

    // Frame-level view: CONFIRM identical complete scans accept a new frame;
    // a one-character left shift emits the new right digit, anything else all four.
    task automatic modelScan(input logic [27:0] f);
        if (f == modelCand) begin
            if (modelCnt < 15) modelCnt++;
        end else begin
            modelCand = f;
            modelCnt  = 1;
        end
        if (modelCnt == CONFIRM && modelCand != modelAcc) begin
            expFrames.push_back(modelCand);
            if (modelCand[27:7] == modelAcc[20:0]) begin
                modelPush(modelCand[6:0]);
            end else begin
                for (int k = 3; k >= 0; k--) modelPush(modelCand[k*7 +: 7]);
            end
            modelAcc = modelCand;
        end
    endtask

    // Blank gap, then select the digit with segment data lagging by 'lag' cycles.
    task automatic scanDigit(input int idx, input logic [6:0] p, input int lag, input int hold, input int gap);
        logic [3:0] sel;
        dig_in = 4'b1111;
        seg_in = 7'h00;
        tick(gap);
        sel      = 4'b1111;
        sel[idx] = 1'b0;
        dig_in   = sel;
        tick(lag);
        seg_in = p;
        tick(hold - lag);
    endtask

    task automatic applyStimulus(input logic [27:0] f);
        int order [4];
        int j, t;
        for (int i = 0; i < 4; i++) order[i] = 3 - i;
        for (int i = 3; i > 0; i--) begin
            j        = $urandom_range(i, 0);
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 4; i++) begin
            scanDigit(order[i], f[order[i]*7 +: 7], $urandom_range(2, 0),
                      SETTLE + 3 + $urandom_range(3, 0), $urandom_range(3, 1));
        end
        modelScan(f);
    endtask

    task automatic checkQueues(input string tag);
        tick(20);
        checkOutput({tag, "/frameCount"}, obsFrames.size(), expFrames.size());
        while (obsFrames.size() > 0 && expFrames.size() > 0)
            checkOutput({tag, "/frame"}, 32'(obsFrames.pop_front()), 32'(expFrames.pop_front()));
        checkOutput({tag, "/charCount"}, obsChars.size(), expChars.size());
        while (obsChars.size() > 0 && expChars.size() > 0)
            checkOutput({tag, "/char"}, 32'(obsChars.pop_front()), 32'(expChars.pop_front()));
        obsFrames.delete();
        expFrames.delete();
        obsChars.delete();
        expChars.delete();
        checkOutput({tag, "/frameOut"}, 32'(frame), 32'(modelAcc));
        checkOutput({tag, "/overflow"}, 32'(overflow), 32'(modelOvf));
        checkOutput({tag, "/digErr"}, 32'(dig_err), 32'(modelDigErr));
    endtask

    initial begin
        rst        = 1'b1;
        seg_in     = 7'h00;
        dig_in     = 4'b1111;
        char_ready = 1'b1;
        modelReset();
        tick(3);
        checkOutput("reset/frame", 32'(frame), 32'h0);
        checkOutput("reset/frameValid", 32'(frame_valid), 32'h0);
        checkOutput("reset/charCode", 32'(char_code), 32'h0);
        checkOutput("reset/charValid", 32'(char_valid), 32'h0);
        checkOutput("reset/overflow", 32'(overflow), 32'h0);
        checkOutput("reset/digErr", 32'(dig_err), 32'h0);
        rst = 1'b0;
        tick(3);

        scanDigit(3, 7'h5B, 1, SETTLE + 4, 2);
        scanDigit(2, 7'h4F, 2, SETTLE + 4, 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midReset/charValid", 32'(char_valid), 32'h0);
        tick(2);
        rst = 1'b0;
        modelReset();
        tick(2);

        applyStimulus(F0123);
        applyStimulus(F0123);
        tick(20);
        checkOutput("resync/frame0123", 32'(frame), 32'(F0123));
        checkOutput("resync/pulses", obsFrames.size(), 1);
        checkOutput("resync/chars", obsChars.size(), 4);
        checkQueues("resync");

        applyStimulus(F1234);
        applyStimulus(F1234);
        tick(20);
        checkOutput("scroll/chars", obsChars.size(), 1);
        if (obsChars.size() > 0) checkOutput("scroll/char4", 32'(obsChars[0]), 32'(expCode(7'h33)));
        checkQueues("scroll");

        repeat (20) applyStimulus(F1234);
        checkQueues("repeat");

        repeat (6) begin
            applyStimulus(FALTA);
            applyStimulus(FALTB);
        end
        checkQueues("alternate");

        scanDigit(3, FERR[27:21], 2, SETTLE + 3, 1);
        scanDigit(2, FERR[20:14], 0, SETTLE + 3, 1);
        scanDigit(1, FERR[13:7], 1, SETTLE + 3, 1);
        dig_in = 4'b0011;
        seg_in = 7'h7F;
        tick(10);
        checkOutput("digErr/flag", 32'(dig_err), 32'h1);
        modelDigErr = 1'b1;
        scanDigit(0, FERR[6:0], 2, SETTLE + 3, 1);
        modelScan(FERR);
        applyStimulus(FERR);
        checkQueues("digErr");

        char_ready = 1'b0;
        applyStimulus(FX);
        applyStimulus(FX);
        applyStimulus(FY);
        applyStimulus(FY);
        tick(20);
        checkOutput("stall/charValid", 32'(char_valid), 32'h1);
        checkOutput("stall/overflow", 32'(overflow), 32'h1);
        checkOutput("stall/noneTaken", obsChars.size(), 0);
        char_ready = 1'b1;
        modelHeld  = 0;
        checkQueues("drain");
        checkOutput("drain/empty", 32'(char_valid), 32'h0);

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset/overflow", 32'(overflow), 32'h0);
        checkOutput("asyncReset/digErr", 32'(dig_err), 32'h0);
        checkOutput("asyncReset/frame", 32'(frame), 32'h0);
        tick(2);
        rst = 1'b0;
        modelReset();
        tick(2);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1, 0) == 1)
                nextFrame = {modelAcc[20:0], 7'($urandom_range(127, 0))};
            else
                nextFrame = 28'($urandom);
            reps = $urandom_range(3, 1);
            repeat (reps) applyStimulus(nextFrame);
        end
        checkQueues("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
